td4_sequencer: RTL

Multi-cycle fetch/execute controller for the 4-bit TD4 core. It fetches 8-bit instructions from program ROM using a req/ack handshake and holds the architectural state: registers A and B, output latch, PC and carry flag C. Each instruction is executed through the shared 4-bit `alu` adder (dat_in + imdata -> dat_out, carry_flag); the sequencer drives the ALU operands and writes back the result. It sits between the program ROM, the ALU instance and the board I/O pins.

---
 rtl/td4_pkg.sv | 50 +++++
 rtl/td4_decode.sv | 79 +++++++
 rtl/td4_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/td4_pkg.sv
// Shared definitions for the TD4 fetch/execute sequencer: widths, opcodes,
// FSM encoding and the decoder's operand/destination selects.
package td4_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 4;
  localparam int unsigned OP_W       = 4;

  localparam logic [OP_W-1:0] OP_ADD_A   = 4'b0000;
  localparam logic [OP_W-1:0] OP_MOV_A_B = 4'b0001;
  localparam logic [OP_W-1:0] OP_IN_A    = 4'b0010;
  localparam logic [OP_W-1:0] OP_MOV_A   = 4'b0011;
  localparam logic [OP_W-1:0] OP_MOV_B_A = 4'b0100;
  localparam logic [OP_W-1:0] OP_ADD_B   = 4'b0101;
  localparam logic [OP_W-1:0] OP_IN_B    = 4'b0110;
  localparam logic [OP_W-1:0] OP_MOV_B   = 4'b0111;
  localparam logic [OP_W-1:0] OP_OUT_B   = 4'b1001;
  localparam logic [OP_W-1:0] OP_OUT_IM  = 4'b1011;
  localparam logic [OP_W-1:0] OP_JNC     = 4'b1110;
  localparam logic [OP_W-1:0] OP_JMP     = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_e;

  // Source for the ALU dat_in operand
  typedef enum logic [1:0] {
    SEL_A_ZERO  = 2'd0,
    SEL_A_REG_A = 2'd1,
    SEL_A_REG_B = 2'd2,
    SEL_A_IN    = 2'd3
  } sel_a_e;

  // Source for the ALU imdata operand
  typedef enum logic {
    SEL_B_ZERO = 1'b0,
    SEL_B_IMM  = 1'b1
  } sel_b_e;

  typedef enum logic [2:0] {
    DST_NONE = 3'd0,
    DST_A    = 3'd1,
    DST_B    = 3'd2,
    DST_OUT  = 3'd3,
    DST_PC   = 3'd4
  } dst_e;

endpackage

// File: rtl/td4_decode.sv
// Combinational TD4 instruction decoder: opcode and carry flag to ALU operand
// selects, writeback destination, jump decision and undefined-opcode flag.
module td4_decode
  import td4_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  input  logic            c,
  output sel_a_e          sel_a,
  output sel_b_e          sel_b,
  output dst_e            dst,
  output logic            jump_taken,
  output logic            illegal
);

  always_comb begin
    sel_a      = SEL_A_ZERO;
    sel_b      = SEL_B_ZERO;
    dst        = DST_NONE;
    jump_taken = 1'b0;
    illegal    = 1'b0;
    case (opcode)
      OP_ADD_A: begin
        sel_a = SEL_A_REG_A;
        sel_b = SEL_B_IMM;
        dst   = DST_A;
      end
      OP_ADD_B: begin
        sel_a = SEL_A_REG_B;
        sel_b = SEL_B_IMM;
        dst   = DST_B;
      end
      OP_MOV_A: begin
        sel_b = SEL_B_IMM;
        dst   = DST_A;
      end
      OP_MOV_B: begin
        sel_b = SEL_B_IMM;
        dst   = DST_B;
      end
      OP_MOV_A_B: begin
        sel_a = SEL_A_REG_B;
        dst   = DST_A;
      end
      OP_MOV_B_A: begin
        sel_a = SEL_A_REG_A;
        dst   = DST_B;
      end
      OP_IN_A: begin
        sel_a = SEL_A_IN;
        dst   = DST_A;
      end
      OP_IN_B: begin
        sel_a = SEL_A_IN;
        dst   = DST_B;
      end
      OP_OUT_IM: begin
        sel_b = SEL_B_IMM;
        dst   = DST_OUT;
      end
      OP_OUT_B: begin
        sel_a = SEL_A_REG_B;
        dst   = DST_OUT;
      end
      OP_JMP: begin
        sel_b      = SEL_B_IMM;
        dst        = DST_PC;
        jump_taken = 1'b1;
      end
      // Conditional on the carry left by the previous instruction
      OP_JNC: begin
        sel_b      = SEL_B_IMM;
        jump_taken = ~c;
        dst        = c ? DST_NONE : DST_PC;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/td4_sequencer.sv
// TD4 fetch/execute controller: fetches over a req/ack ROM handshake, executes
// each instruction in one cycle through the external ALU and holds A, B, OUT, PC, C.
module td4_sequencer
  import td4_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic                   run,
  output logic                   rom_req,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic                   rom_ack,
  input  logic [OP_W+DATA_W-1:0] rom_data,
  input  logic [DATA_W-1:0]      in_port,
  output logic [DATA_W-1:0]      out_port,
  output logic [DATA_W-1:0]      alu_dat_in,
  output logic [DATA_W-1:0]      alu_imdata,
  input  logic [DATA_W-1:0]      alu_dat_out,
  input  logic                   alu_carry,
  output logic                   retire,
  output logic                   illegal
);

  localparam int unsigned INSTR_W = OP_W + DATA_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic                c_q, c_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;

  logic [OP_W-1:0]     ir_op;
  logic [DATA_W-1:0]   ir_imm;
  logic                exec;
  sel_a_e              sel_a;
  sel_b_e              sel_b;
  dst_e                dst;
  logic                jump_taken;
  logic                dec_illegal;
  logic [DATA_W-1:0]   dat_in_c;
  logic [DATA_W-1:0]   imdata_c;

  assign ir_op  = ir_q[INSTR_W-1 -: OP_W];
  assign ir_imm = ir_q[DATA_W-1:0];
  assign exec   = (state_q == ST_EXEC);

  td4_decode u_decode (
    .opcode     (ir_op),
    .c          (c_q),
    .sel_a      (sel_a),
    .sel_b      (sel_b),
    .dst        (dst),
    .jump_taken (jump_taken),
    .illegal    (dec_illegal)
  );

  // ALU operands are only live during EXEC so the adder sees zeros otherwise
  always_comb begin
    dat_in_c = '0;
    imdata_c = '0;
    if (exec) begin
      case (sel_a)
        SEL_A_REG_A: dat_in_c = a_q;
        SEL_A_REG_B: dat_in_c = b_q;
        SEL_A_IN:    dat_in_c = in_port;
        default:     dat_in_c = '0;
      endcase
      if (sel_b == SEL_B_IMM) begin
        imdata_c = ir_imm;
      end
    end
  end

  // Next-state and writeback
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    c_d     = c_q;
    ir_d    = ir_q;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (rom_ack) begin
          ir_d    = rom_data;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = run ? ST_FETCH : ST_IDLE;
        pc_d    = jump_taken ? ADDR_W'(alu_dat_out) : pc_q + ADDR_W'(1);
        if (!dec_illegal) begin
          c_d = alu_carry;
        end
        case (dst)
          DST_A:   a_d   = alu_dat_out;
          DST_B:   b_d   = alu_dat_out;
          DST_OUT: out_d = alu_dat_out;
          default: ;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      c_q     <= 1'b0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      c_q     <= c_d;
      ir_q    <= ir_d;
    end
  end

  assign rom_req    = (state_q == ST_FETCH);
  assign rom_addr   = pc_q;
  assign out_port   = out_q;
  assign alu_dat_in = dat_in_c;
  assign alu_imdata = imdata_c;
  assign retire     = exec;
  assign illegal    = exec & dec_illegal;

endmodule
